// File: rtl/store_mem_port_arbiter.sv
// Arbitrates the single memory port between the load and store issue buffers,
// tracks the one outstanding op, and squashes it on branch misprediction.
module store_mem_port_arbiter #(
    parameter int B_MASK_W   = 8,
    parameter int ALU_NUM    = 2,
    parameter int STARVE_MAX = 4,
    localparam int IDX_W     = $clog2(B_MASK_W),
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_ld_req_valid,
    input  logic [B_MASK_W-1:0]        i_ld_req_b_mask,
    input  logic                       i_st_req_valid,
    input  logic [B_MASK_W-1:0]        i_st_req_b_mask,
    input  logic                       i_st_urgent,
    input  logic                       i_mem_ack,
    input  logic                       i_clean_brat_en,
    input  logic [IDX_W-1:0]           i_clean_brat_num,
    input  logic [ALU_NUM-1:0]         i_clean_bit_brat_en,
    input  logic [ALU_NUM*IDX_W-1:0]   i_clean_bit_num_brat_ex,
    output logic                       o_stop_is_ld_en,
    output logic                       o_stop_is_st_en,
    output logic                       o_mem_req_valid,
    output logic                       o_mem_req_is_st,
    output logic                       o_ld_resp_valid,
    output logic                       o_st_resp_valid,
    output logic [CNT_W-1:0]           o_st_starve_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_LD = 2'd1,
        S_BUSY_ST = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [B_MASK_W-1:0] r_out_mask;
    logic [CNT_W-1:0]    r_st_starve_cnt;

    logic [B_MASK_W-1:0] w_clr_vec;
    logic                w_busy;
    logic                w_port_free;
    logic                w_ld_elig;
    logic                w_st_elig;
    logic                w_st_grant;
    logic                w_ld_grant;
    logic                w_out_squash;
    logic                w_ld_resp;
    logic                w_st_resp;

    // Correct-prediction bit clears from all resolution ports merged into one vector.
    always_comb begin
        w_clr_vec = '0;
        for (int j = 0; j < ALU_NUM; j++) begin
            if (i_clean_bit_brat_en[j]) begin
                w_clr_vec[i_clean_bit_num_brat_ex[j*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy      = (r_state == S_BUSY_LD) || (r_state == S_BUSY_ST);
        w_port_free = (r_state == S_IDLE) || i_mem_ack;

        // Gating with i_reset keeps every output at its idle value while reset is held.
        w_ld_elig = i_reset && i_ld_req_valid &&
                    !(i_clean_brat_en && i_ld_req_b_mask[i_clean_brat_num]);
        w_st_elig = i_reset && i_st_req_valid &&
                    !(i_clean_brat_en && i_st_req_b_mask[i_clean_brat_num]);

        w_st_grant = w_port_free && w_st_elig &&
                     (i_st_urgent || (r_st_starve_cnt == CNT_MAX) || !w_ld_elig);
        w_ld_grant = w_port_free && w_ld_elig && !w_st_grant;

        // Squash test uses the registered mask, before this cycle's bit clears.
        w_out_squash = w_busy && i_clean_brat_en && r_out_mask[i_clean_brat_num];

        w_ld_resp = i_reset && (r_state == S_BUSY_LD) && i_mem_ack && !w_out_squash;
        w_st_resp = i_reset && (r_state == S_BUSY_ST) && i_mem_ack && !w_out_squash;
    end

    assign o_stop_is_ld_en = !w_ld_grant;
    assign o_stop_is_st_en = !w_st_grant;
    assign o_mem_req_valid = w_ld_grant || w_st_grant;
    assign o_mem_req_is_st = w_st_grant;
    assign o_ld_resp_valid = w_ld_resp;
    assign o_st_resp_valid = w_st_resp;
    assign o_st_starve_cnt = r_st_starve_cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= S_IDLE;
            r_out_mask      <= '0;
            r_st_starve_cnt <= '0;
        end else begin
            if (w_st_grant) begin
                r_st_starve_cnt <= '0;
            end else if (i_st_req_valid && (r_st_starve_cnt != CNT_MAX)) begin
                r_st_starve_cnt <= r_st_starve_cnt + 1'b1;
            end

            if (w_st_grant) begin
                r_state    <= S_BUSY_ST;
                r_out_mask <= i_st_req_b_mask & ~w_clr_vec;
            end else if (w_ld_grant) begin
                r_state    <= S_BUSY_LD;
                r_out_mask <= i_ld_req_b_mask & ~w_clr_vec;
            end else begin
                case (r_state)
                    S_BUSY_LD, S_BUSY_ST: begin
                        if (i_mem_ack) begin
                            r_state    <= S_IDLE;
                            r_out_mask <= '0;
                        end else if (w_out_squash) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_out_mask <= r_out_mask & ~w_clr_vec;
                        end
                    end
                    S_DRAIN: begin
                        if (i_mem_ack) begin
                            r_state    <= S_IDLE;
                            r_out_mask <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_store_mem_port_arbiter.sv
// Directed scoreboard bench for store_mem_port_arbiter: stimulus pushes the
// hand-computed per-cycle response, a monitor pops and compares on each negedge.
module tb_store_mem_port_arbiter;

    localparam int B_MASK_W   = 8;
    localparam int ALU_NUM    = 2;
    localparam int STARVE_MAX = 4;
    localparam int IDX_W      = $clog2(B_MASK_W);
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);

    logic                     clk;
    logic                     rst_n;
    logic                     ld_v;
    logic [B_MASK_W-1:0]      ld_m;
    logic                     st_v;
    logic [B_MASK_W-1:0]      st_m;
    logic                     urg;
    logic                     ack;
    logic                     cb_en;
    logic [IDX_W-1:0]         cb_num;
    logic [ALU_NUM-1:0]       cbit_en;
    logic [ALU_NUM*IDX_W-1:0] cbit_num;

    logic                     stop_ld, stop_st, req_v, req_st, ld_resp, st_resp;
    logic [CNT_W-1:0]         cnt;

    store_mem_port_arbiter #(
        .B_MASK_W  (B_MASK_W),
        .ALU_NUM   (ALU_NUM),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clock                (clk),
        .i_reset                (rst_n),
        .i_ld_req_valid         (ld_v),
        .i_ld_req_b_mask        (ld_m),
        .i_st_req_valid         (st_v),
        .i_st_req_b_mask        (st_m),
        .i_st_urgent            (urg),
        .i_mem_ack              (ack),
        .i_clean_brat_en        (cb_en),
        .i_clean_brat_num       (cb_num),
        .i_clean_bit_brat_en    (cbit_en),
        .i_clean_bit_num_brat_ex(cbit_num),
        .o_stop_is_ld_en        (stop_ld),
        .o_stop_is_st_en        (stop_st),
        .o_mem_req_valid        (req_v),
        .o_mem_req_is_st        (req_st),
        .o_ld_resp_valid        (ld_resp),
        .o_st_resp_valid        (st_resp),
        .o_st_starve_cnt        (cnt)
    );

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: req_v, req_st, ld_resp, st_resp, stop_ld, stop_st, cnt[2:0]
    function automatic logic [8:0] mk(input logic rv, input logic rs, input logic lr,
                                      input logic sr, input logic sl, input logic ss,
                                      input int c);
        logic [2:0] c3;
        c3 = 3'(c);
        return {rv, rs, lr, sr, sl, ss, c3};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {req_v, req_st, ld_resp, st_resp, stop_ld, stop_st, 3'(cnt)};
            n_checks++;
            if (act !== e.v) begin
                n_errors++;
                $display("FAIL %s: got rv=%b rs=%b lr=%b sr=%b sl=%b ss=%b cnt=%0d, want rv=%b rs=%b lr=%b sr=%b sl=%b ss=%b cnt=%0d",
                         e.tag, act[8], act[7], act[6], act[5], act[4], act[3], act[2:0],
                         e.v[8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3], e.v[2:0]);
            end
        end
    end

    task automatic clr_in();
        ld_v = 0; ld_m = '0; st_v = 0; st_m = '0; urg = 0; ack = 0;
        cb_en = 0; cb_num = '0; cbit_en = '0; cbit_num = '0;
    endtask

    task automatic tick(input string tag, input logic [8:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clr_in();
        repeat (2) @(posedge clk);
        #1;

        clr_in(); ld_v = 1; st_v = 1;
        tick("rst_hold", mk(0,0,0,0,1,1,0));

        // Load preferred, then starvation forces the store through
        rst_n = 1'b1;
        clr_in(); ld_v = 1; st_v = 1;
        tick("ld_first", mk(1,0,0,0,0,1,0));
        clr_in(); ld_v = 1; st_v = 1; ack = 1;
        tick("b2b_cnt1", mk(1,0,1,0,0,1,1));
        clr_in(); ld_v = 1; st_v = 1; ack = 1;
        tick("b2b_cnt2", mk(1,0,1,0,0,1,2));
        clr_in(); ld_v = 1; st_v = 1; ack = 1;
        tick("b2b_cnt3", mk(1,0,1,0,0,1,3));
        clr_in(); ld_v = 1; st_v = 1; ack = 1;
        tick("starve_st", mk(1,1,1,0,1,0,4));
        clr_in(); ack = 1;
        tick("st_resp1", mk(0,0,0,1,1,1,0));

        // Urgent store, counting while port busy, lone store
        clr_in(); ld_v = 1; st_v = 1; urg = 1;
        tick("urgent_st", mk(1,1,0,0,1,0,0));
        clr_in(); ld_v = 1;
        tick("busy_nost", mk(0,0,0,0,1,1,0));
        clr_in(); st_v = 1;
        tick("busy_st", mk(0,0,0,0,1,1,0));
        clr_in(); ack = 1;
        tick("st_resp2", mk(0,0,0,1,1,1,1));
        clr_in(); st_v = 1;
        tick("lone_st", mk(1,1,0,0,1,0,1));
        clr_in(); ack = 1;
        tick("st_resp3", mk(0,0,0,1,1,1,0));

        // Killed candidates
        clr_in(); st_v = 1; st_m = 8'h02; cb_en = 1; cb_num = 3'd1;
        tick("st_killed", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1; ld_m = 8'h01; st_v = 1; cb_en = 1; cb_num = 3'd0;
        tick("ld_killed", mk(1,1,0,0,1,0,1));
        clr_in(); ack = 1;
        tick("st_resp4", mk(0,0,0,1,1,1,0));
        clr_in(); ack = 1;
        tick("idle_ack", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1;
        tick("ld_grant2", mk(1,0,0,0,0,1,0));
        clr_in(); ack = 1;
        tick("ld_resp2", mk(0,0,1,0,1,1,0));

        // Squash without ack -> DRAIN, ack swallowed, grant in ack cycle
        clr_in(); ld_v = 1; ld_m = 8'h04;
        tick("ld_m04", mk(1,0,0,0,0,1,0));
        clr_in(); cb_en = 1; cb_num = 3'd2;
        tick("squash", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1;
        tick("drain1", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1;
        tick("drain2", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1; ack = 1;
        tick("drain_ack", mk(1,0,0,0,0,1,0));
        clr_in(); ack = 1;
        tick("ld_resp3", mk(0,0,1,0,1,1,0));

        // Bit clear one cycle before the squash prevents it
        clr_in(); ld_v = 1; ld_m = 8'h04;
        tick("ld_m04b", mk(1,0,0,0,0,1,0));
        clr_in(); cbit_en = 2'b01; cbit_num = {3'd0, 3'd2};
        tick("bit_clr", mk(0,0,0,0,1,1,0));
        clr_in(); cb_en = 1; cb_num = 3'd2;
        tick("no_squash", mk(0,0,0,0,1,1,0));
        clr_in(); ack = 1;
        tick("ld_resp4", mk(0,0,1,0,1,1,0));

        // Squash and clear together: squash sees pre-clear mask
        clr_in(); ld_v = 1; ld_m = 8'h08;
        tick("ld_m08", mk(1,0,0,0,0,1,0));
        clr_in(); cb_en = 1; cb_num = 3'd3; cbit_en = 2'b10; cbit_num = {3'd3, 3'd0}; ack = 1;
        tick("sq_clr_ack", mk(0,0,0,0,1,1,0));
        clr_in();
        tick("idle_after", mk(0,0,0,0,1,1,0));

        // Clear applied to the mask captured at grant
        clr_in(); ld_v = 1; ld_m = 8'h02; cbit_en = 2'b10; cbit_num = {3'd1, 3'd0};
        tick("grant_clr", mk(1,0,0,0,0,1,0));
        clr_in(); cb_en = 1; cb_num = 3'd1; ack = 1;
        tick("ld_resp5", mk(0,0,1,0,1,1,0));

        // Store squashed in its ack cycle
        clr_in(); st_v = 1; st_m = 8'h10;
        tick("st_m10", mk(1,1,0,0,1,0,0));
        clr_in(); cb_en = 1; cb_num = 3'd4; ack = 1;
        tick("st_sq_ack", mk(0,0,0,0,1,1,0));

        // Reset mid BUSY_ST, then a stray ack
        clr_in(); st_v = 1;
        tick("st_grant5", mk(1,1,0,0,1,0,0));
        clr_in(); st_v = 1;
        tick("st_wait1", mk(0,0,0,0,1,1,0));
        clr_in(); st_v = 1;
        tick("st_wait2", mk(0,0,0,0,1,1,1));
        rst_n = 1'b0;
        clr_in(); st_v = 1; ld_v = 1; ack = 1;
        tick("mid_reset", mk(0,0,0,0,1,1,0));
        rst_n = 1'b1;
        clr_in(); ack = 1;
        tick("stray_ack", mk(0,0,0,0,1,1,0));
        clr_in(); ld_v = 1;
        tick("post_rst_ld", mk(1,0,0,0,0,1,0));
        clr_in(); ack = 1;
        tick("ld_resp6", mk(0,0,1,0,1,1,0));

        clr_in();
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_mem_port_arbiter.md
Name: store_mem_port_arbiter

Overview:
- Shares the single D-cache/memory access port between the load issue buffer and the store issue buffer.
- Drives each buffer's stop-issue input (stop_is_st_en / stop_is_ld_en) and tracks the one outstanding memory op.
- Squashes that op on branch misprediction and updates its branch mask on branch resolution.
- Sits between the issue buffers and the EX/memory stage.

Parameters:
B_MASK_W, 8, branch-mask width (`width_b_mask`)
ALU_NUM, 2, number of branch-resolution ports (`ALU_num`)
STARVE_MAX, 4, cycles a pending store may lose arbitration before it is forced through

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ld_req_valid  in  1  load issue buffer head is valid
ld_req_b_mask  in  B_MASK_W  branch mask of load head
st_req_valid  in  1  store issue buffer head is valid
st_req_b_mask  in  B_MASK_W  branch mask of store head
st_urgent  in  1  store queue near full; store wins arbitration
mem_ack  in  1  memory port completes outstanding op this cycle
clean_brat_en  in  1  misprediction squash
clean_brat_num  in  $clog2(B_MASK_W)  squashed branch bit
clean_bit_brat_en  in  ALU_NUM  correct-prediction bit clear, per port
clean_bit_num_brat_ex  in  ALU_NUM*$clog2(B_MASK_W)  bit to clear, per port
stop_is_ld_en  out  1  1 = load buffer must not issue this cycle
stop_is_st_en  out  1  1 = store buffer must not issue this cycle
mem_req_valid  out  1  op launched to memory port this cycle
mem_req_is_st  out  1  launched op is a store
ld_resp_valid  out  1  non-squashed load completed (pulse)
st_resp_valid  out  1  non-squashed store completed (pulse)
st_starve_cnt  out  $clog2(STARVE_MAX+1)  current store starvation count

Behaviour:
- FSM states:
  - IDLE: no op outstanding.
  - BUSY_LD / BUSY_ST: op outstanding.
  - DRAIN: squashed op outstanding; its ack is swallowed.
- Registers: state, outstanding b_mask (out_mask), st_starve_cnt.
- port_free = (state==IDLE) || mem_ack. Ack and a new grant in the same cycle are allowed (back-to-back).
- Candidate eligibility: valid, and not killed this cycle. A candidate is killed when clean_brat_en && b_mask[clean_brat_num].
- Arbitration, only when port_free:
  - Store wins if eligible and (st_urgent || st_starve_cnt==STARVE_MAX || no eligible load).
  - Otherwise an eligible load wins.
- Grant effects (combinational, same cycle):
  - Winner's stop_is_*_en=0; loser's stop=1; no grant → both stops=1.
  - mem_req_valid=1; mem_req_is_st=1 for a store grant.
- Next state after a grant: BUSY_ST or BUSY_LD; out_mask = granted b_mask with this cycle's bit clears applied.
- Starvation counter:
  - Resets to 0 on a store grant.
  - Increments, saturating at STARVE_MAX, each cycle st_req_valid=1 with no store grant (including when the port is not free).
  - Holds otherwise.
- On mem_ack in BUSY_LD / BUSY_ST:
  - Pulse ld_resp_valid / st_resp_valid, unless the op is squashed that same cycle.
  - Go to IDLE, or to the new grant's state.
- Squash of the outstanding op: if clean_brat_en && out_mask[clean_brat_num] in BUSY_*:
  - Without mem_ack → go to DRAIN.
  - With mem_ack → suppress resp, go to IDLE.
- DRAIN: both stops=1 and no resp pulse until mem_ack. On mem_ack → IDLE; a new grant in that ack cycle is allowed.
- Bit clear: for each j with clean_bit_brat_en[j], clear out_mask[clean_bit_num_brat_ex[j]]. When squash and clear hit the same cycle, the squash test uses the pre-clear mask.
- mem_ack in IDLE is ignored: no resp, no state change.
- Reset (reset=0), any time including mid-op:
  - state=IDLE, out_mask=0, st_starve_cnt=0.
  - Outputs forced: stops=1, mem_req_valid=0, mem_req_is_st=0, resp pulses=0.
  - An in-flight ack after reset release while IDLE is ignored.

Test Plan:
- Load and store both valid in IDLE, st_urgent=0, cnt=0 → load granted: stop_is_ld_en=0, stop_is_st_en=1, mem_req_is_st=0; cnt becomes 1.
- Store held valid with loads granted back-to-back (mem_ack each cycle) → cnt counts 1,2,3,4; next free cycle grants the store and cnt returns to 0.
- Load outstanding with out_mask=8'b0000_0100; clean_brat_en=1, clean_brat_num=2, no ack → DRAIN. Ack 3 cycles later → ld_resp_valid stays 0, state IDLE.
- Same setup but clean_bit_brat_en[0]=1, num=2 one cycle before the squash → out_mask=0, no DRAIN, ld_resp_valid pulses on ack.
- Store head with b_mask bit 1 set, clean_brat_en=1, num=1 in IDLE → no grant, both stops=1, mem_req_valid=0.
- Reset pulsed low mid BUSY_ST → all outputs at reset values immediately. After release, a stray mem_ack produces no resp and the FSM stays IDLE.
